// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with accumulator and valid/ready handshakes on both sides.
// Stage 1 registers the operand beat; stage 2 registers the result, flags and out_valid.
module alu_pipe_acc #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_ADD     = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_ACC_ADD = 3'b101;
    localparam logic [2:0] OP_ACC_LD  = 3'b110;
    localparam logic [2:0] OP_ACC_SUB = 3'b111;

    // Returns {carry_or_borrow, signed_overflow, result}.
    function automatic logic [WIDTH+1:0] addsub(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y,
                                                input logic sub);
        logic [WIDTH:0]          ext;
        logic signed [WIDTH-1:0] r;
        logic                    v;
        ext = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r   = ext[WIDTH-1:0];
        if (sub)
            v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        else
            v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return {ext[WIDTH], v, r};
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_code_q,  s1_code_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic             adv2;
    logic [WIDTH+1:0] as_res;
    logic [WIDTH-1:0] res_c;
    logic             res_carry;
    logic             res_ovf;
    logic             acc_wr;

    assign adv2     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !rst && (!s1_valid_q || adv2);
    assign accept   = in_valid && in_ready;

    // Result is formed from the S1 beat and the accumulator as it stands at the transfer edge,
    // so a chain of accumulator opcodes reads the value written by its predecessor.
    always_comb begin
        as_res    = '0;
        res_c     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        acc_wr    = 1'b0;
        unique case (s1_code_q)
            OP_AND: res_c = s1_a_q & s1_b_q;
            OP_OR:  res_c = s1_a_q | s1_b_q;
            OP_XOR: res_c = s1_a_q ^ s1_b_q;
            OP_SUB, OP_ADD: begin
                as_res = addsub(s1_a_q, s1_b_q, s1_code_q == OP_SUB);
                {res_carry, res_ovf, res_c} = as_res;
            end
            OP_ACC_ADD, OP_ACC_SUB: begin
                as_res = addsub(acc_q, s1_a_q, s1_code_q == OP_ACC_SUB);
                {res_carry, res_ovf, res_c} = as_res;
                acc_wr = 1'b1;
            end
            OP_ACC_LD: begin
                res_c  = s1_a_q;
                acc_wr = 1'b1;
            end
            default: res_c = '0;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
        if (adv2) begin
            out_valid_d = 1'b1;
            c_d         = res_c;
            carry_d     = res_carry;
            zero_d      = (res_c == '0);
            ovf_d       = res_ovf;
            if (acc_wr)
                acc_d = res_c;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stage 1 -> stage 2 boundary: control and visible outputs are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= ACC_RST;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
        end
    end

    // Input capture: operand data is qualified by s1_valid_q and needs no reset.
    always_ff @(posedge clk) begin
        s1_code_q <= s1_code_d;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// Scoreboard bench for alu_pipe_acc: expected beats are queued at input acceptance
// and compared when the DUT completes an output beat.
module tb_alu_pipe_acc;
    localparam int W = 4;
    localparam logic [W-1:0] ACC_RST_V = 4'h0;

    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_SUB = 3'd2, OP_ADD = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_AADD = 3'd5, OP_ALD = 3'd6, OP_ASUB = 3'd7;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [2:0]   code;
    logic [W-1:0] a, b;
    logic         out_valid, out_ready;
    logic [W-1:0] c;
    logic         carry, zero, ovf;
    logic [W-1:0] acc;

    alu_pipe_acc #(.WIDTH(W), .ACC_RST(ACC_RST_V)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .carry(carry), .zero(zero), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         carry;
        logic         zero;
        logic         ovf;
        logic [W-1:0] acc;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_out = 0;
    logic [W-1:0] m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sval(input logic [W-1:0] v);
        return v[W-1] ? int'(v) - (1 << W) : int'(v);
    endfunction

    // Reference arithmetic written on plain integers.
    function automatic exp_t arith(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub);
        exp_t e;
        int   s, sv;
        e = '0;
        if (sub) begin
            s       = int'(x) - int'(y);
            sv      = sval(x) - sval(y);
            e.carry = (x < y);
        end else begin
            s       = int'(x) + int'(y);
            sv      = sval(x) + sval(y);
            e.carry = (s >= (1 << W));
        end
        e.c   = s[W-1:0];
        e.ovf = (sv < -(1 << (W-1))) || (sv > (1 << (W-1)) - 1);
        return e;
    endfunction

    function automatic exp_t model(input logic [2:0] cd, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = '0;
        case (cd)
            OP_AND:  e.c = x & y;
            OP_OR:   e.c = x | y;
            OP_XOR:  e.c = x ^ y;
            OP_SUB:  e = arith(x, y, 1'b1);
            OP_ADD:  e = arith(x, y, 1'b0);
            OP_AADD: begin e = arith(m_acc, x, 1'b0); m_acc = e.c; end
            OP_ASUB: begin e = arith(m_acc, x, 1'b1); m_acc = e.c; end
            default: begin e.c = x; m_acc = x; end
        endcase
        e.zero = (e.c == '0);
        e.acc  = m_acc;
        return e;
    endfunction

    // One cycle, entered and left on a falling edge; handshakes sampled mid low phase.
    task automatic step(input logic iv, input logic [2:0] cd, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ordy,
                        output logic acc_o, output logic done_o);
        exp_t e;
        in_valid  = iv;
        code      = cd;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        acc_o  = iv && in_ready;
        done_o = out_valid && out_ready;
        if (done_o) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("c", 32'(c), 32'(e.c));
                check("carry", 32'(carry), 32'(e.carry));
                check("zero", 32'(zero), 32'(e.zero));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("acc", 32'(acc), 32'(e.acc));
            end
        end
        if (acc_o) sb.push_back(model(cd, aa, bb));
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] cd, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic ac, dn;
        int   n;
        ac = 1'b0;
        n  = 0;
        while (!ac && n < 50) begin
            step(1'b1, cd, aa, bb, 1'b1, ac, dn);
            n++;
        end
        if (!ac) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        logic ac, dn;
        int   n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            step(1'b0, 3'd0, '0, '0, 1'b1, ac, dn);
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic ac, dn, have;
        logic [2:0] rc;
        logic [W-1:0] ra, rb, held_c;
        int cnt, cyc, out0, spur;

        rst = 1'b0; in_valid = 1'b0; code = '0; a = '0; b = '0; out_ready = 1'b0;
        m_acc = ACC_RST_V;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_flags", 32'({carry, zero, ovf}), 32'd0);
        check("rst_acc", 32'(acc), 32'(ACC_RST_V));
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Latency: accepted beat visible two edges later.
        step(1'b1, OP_ADD, 4'h2, 4'h3, 1'b1, ac, dn);
        check("lat_accept", 32'(ac), 32'd1);
        check("lat_edge1", 32'(out_valid), 32'd0);
        step(1'b0, 3'd0, '0, '0, 1'b1, ac, dn);
        check("lat_edge2", 32'(out_valid), 32'd1);
        drain();

        // Directed arithmetic/logic beats, then a back-to-back accumulator chain.
        send(OP_ADD, 4'hF, 4'h1);
        send(OP_ADD, 4'h7, 4'h1);
        send(OP_SUB, 4'h3, 4'h5);
        send(OP_SUB, 4'h8, 4'h1);
        send(OP_AND, 4'hC, 4'hA);
        send(OP_OR,  4'hC, 4'h3);
        send(OP_XOR, 4'hF, 4'hF);
        cnt = 0;
        step(1'b1, OP_ALD,  4'h5, 4'h0, 1'b1, ac, dn); cnt += int'(ac);
        step(1'b1, OP_AADD, 4'h3, 4'h0, 1'b1, ac, dn); cnt += int'(ac);
        step(1'b1, OP_AADD, 4'h9, 4'h0, 1'b1, ac, dn); cnt += int'(ac);
        step(1'b1, OP_ASUB, 4'h2, 4'h0, 1'b1, ac, dn); cnt += int'(ac);
        check("acc_chain_accepts", 32'(cnt), 32'd4);
        drain();
        check("acc_chain_final", 32'(acc), 32'hF);

        // Stall: four ADD beats offered with out_ready low for six cycles.
        out0 = n_out;
        cnt  = 0;
        held_c = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, OP_ADD, W'(cnt + 1), W'(2 * cnt), 1'b0, ac, dn);
            if (i >= 2) check("stall_in_ready", 32'(ac), 32'd0);
            if (i == 2) held_c = c;
            if (i > 2) check("stall_hold_c", 32'(c), 32'(held_c));
            if (ac) cnt++;
        end
        check("stall_accepted", 32'(cnt), 32'd2);
        check("stall_acc_hold", 32'(acc), 32'hF);
        while (cnt < 4) begin
            send(OP_ADD, W'(cnt + 1), W'(2 * cnt));
            cnt++;
        end
        drain();
        check("stall_outputs", 32'(n_out - out0), 32'd4);

        // Random valid/ready traffic; producer holds a beat until it is taken.
        have = 1'b0; cnt = 0; cyc = 0; rc = '0; ra = '0; rb = '0;
        while (cnt < 1000 && cyc < 20000) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                rc = 3'($urandom_range(0, 7));
                ra = W'($urandom_range(0, 15));
                rb = W'($urandom_range(0, 15));
            end
            step(have, rc, ra, rb, $urandom_range(0, 3) != 0, ac, dn);
            if (ac) begin have = 1'b0; cnt++; end
            cyc++;
        end
        check("rand_beats", 32'(cnt), 32'd1000);
        drain();

        // Full throughput with both sides held high.
        cnt = 0;
        out0 = n_out;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, OP_ADD, W'(i), W'(3 * i), 1'b1, ac, dn);
            cnt += int'(ac);
        end
        check("tput_accepts", 32'(cnt), 32'd20);
        check("tput_outputs", 32'(n_out - out0), 32'd18);
        drain();

        // Reset with two accumulator beats in flight.
        step(1'b1, OP_AADD, 4'h1, 4'h0, 1'b1, ac, dn);
        step(1'b1, OP_AADD, 4'h2, 4'h0, 1'b1, ac, dn);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_acc", 32'(acc), 32'(ACC_RST_V));
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        m_acc = ACC_RST_V;
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'd0, '0, '0, 1'b1, ac, dn);
            if (out_valid) spur++;
        end
        check("midrst_no_spurious", 32'(spur), 32'd0);
        send(OP_AADD, 4'h3, 4'h0);
        drain();
        check("post_rst_acc", 32'(acc), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
